regfile_wr_arbiter: RTL and testbench

//  Shares the single register-file write port (a bank of D flip-flop registers) among

---
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter.sv | 78 +++++++
 tb/tb_regfile_wr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus between the producers (ALU, FPU, load unit) and the register-file write arbiter.
// The master side drives the requests and the regfile back-pressure; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 64,
    parameter int AW   = 5
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_block;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [IW-1:0]      grant_id;

    modport master (
        output req_valid, req_addr, req_data, wr_block,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_block,
        output req_ready, wr_en, wr_addr, wr_data, grant_id
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ producers,
// with a registered write stage one cycle after the handshake.
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 64,
    parameter int AW   = 5,
    parameter int ZREG = 31
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic          xfer;
    logic [IW:0]   scan_sum;
    logic [IW-1:0] scan_idx;

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign addr_arr[i] = bus.req_addr[i*AW +: AW];
        assign data_arr[i] = bus.req_data[i*DW +: DW];
    end

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NREQ so non-power-of-2 counts never alias.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IW+1)'(NREQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Reset gates the grant so nothing handshakes while the block is held in reset.
    assign xfer = grant_found & ~bus.wr_block & reset;

    always_comb begin
        bus.req_ready = '0;
        if (xfer) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.grant_id <= '0;
            rr_ptr       <= '0;
        end else if (xfer) begin
            bus.wr_en    <= (addr_arr[grant_idx] != AW'(ZREG));
            bus.wr_addr  <= addr_arr[grant_idx];
            bus.wr_data  <= data_arr[grant_idx];
            bus.grant_id <= grant_idx;
            rr_ptr       <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
            bus.wr_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: expected beats are queued at the handshake
// and compared against the registered write port one clock later.
module tb_regfile_wr_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int ZREG = 31;
    localparam int IW   = $clog2(NREQ);

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .ZREG(ZREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t         sb[$];
    beat_t         last;
    int            ptr;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] m_addr [NREQ];
    logic [DW-1:0] m_data [NREQ];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_addr[i] = a;
        m_data[i] = d;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    function automatic int model_arb(input logic [NREQ-1:0] v, input int p);
        int g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (p + k) % NREQ;
            if (g < 0 && v[i]) g = i;
        end
        return g;
    endfunction

    // Drive one cycle: check the grant, queue the expected beat, then check the write port.
    task automatic step(input logic [NREQ-1:0] v, input logic blk, input string tag, output int g);
        logic [NREQ-1:0] exp_ready;
        beat_t b;
        int gm;
        bus.req_valid = v;
        bus.wr_block  = blk;
        #1;
        gm = model_arb(v, ptr);
        exp_ready = '0;
        g = -1;
        if (gm >= 0 && !blk) begin
            exp_ready[gm] = 1'b1;
            b.en   = (m_addr[gm] != AW'(ZREG));
            b.addr = m_addr[gm];
            b.data = m_data[gm];
            b.id   = IW'(gm);
            sb.push_back(b);
            ptr = (gm == NREQ - 1) ? 0 : gm + 1;
            g = gm;
        end
        check({tag, ".ready"}, 64'(bus.req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (sb.size() > 0) last = sb.pop_front();
        else               last.en = 1'b0;
        check({tag, ".wr_en"},    64'(bus.wr_en),    64'(last.en));
        check({tag, ".wr_addr"},  64'(bus.wr_addr),  64'(last.addr));
        check({tag, ".wr_data"},  64'(bus.wr_data),  64'(last.data));
        check({tag, ".grant_id"}, 64'(bus.grant_id), 64'(last.id));
    endtask

    initial begin
        int g;
        logic [NREQ-1:0] v;

        bus.req_valid = '1;
        bus.wr_block  = 1'b0;
        set_req(0, 5'd3,  64'h0000_0000_0000_00A0);
        set_req(1, 5'd7,  64'h0000_0000_0000_00B1);
        set_req(2, 5'd12, 64'h0000_0000_0000_00C2);

        // Reset held with all requesters valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready",    64'(bus.req_ready), 64'd0);
        check("rst.wr_en",    64'(bus.wr_en),     64'd0);
        check("rst.wr_addr",  64'(bus.wr_addr),   64'd0);
        check("rst.wr_data",  64'(bus.wr_data),   64'd0);
        check("rst.grant_id", 64'(bus.grant_id),  64'd0);
        reset = 1'b1;
        ptr   = 0;
        last  = '0;

        // All three valid continuously: 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b0, "rr", g);
            check("rr.order", 64'(g), 64'(i % NREQ));
        end

        // Single requester 1.
        set_req(1, 5'd5, 64'hDEAD_BEEF);
        step(3'b010, 1'b0, "single", g);
        check("single.grant", 64'(g), 64'd1);

        // Blocked regfile for three cycles, then unblock.
        set_req(2, 5'd9, 64'h1234_5678_9ABC_DEF0);
        repeat (3) step(3'b100, 1'b1, "block", g);
        step(3'b100, 1'b0, "unblock", g);
        check("unblock.grant", 64'(g), 64'd2);
        step(3'b111, 1'b0, "ptr0", g);
        check("ptr0.grant", 64'(g), 64'd0);

        // Zero-register write: handshake completes, no write enable, pointer advances.
        set_req(0, 5'd31, 64'hFFFF_0000_FFFF_0000);
        step(3'b001, 1'b0, "zreg", g);
        check("zreg.grant", 64'(g), 64'd0);
        set_req(0, 5'd1, 64'h0000_0000_0000_0011);
        step(3'b111, 1'b0, "zreg_ptr", g);
        check("zreg_ptr.grant", 64'(g), 64'd1);

        // Async reset between edges while a write beat is registered.
        step(3'b100, 1'b0, "pre_rst", g);
        check("pre_rst.wr_en", 64'(bus.wr_en), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async.wr_en",    64'(bus.wr_en),     64'd0);
        check("async.wr_addr",  64'(bus.wr_addr),   64'd0);
        check("async.wr_data",  64'(bus.wr_data),   64'd0);
        check("async.grant_id", 64'(bus.grant_id),  64'd0);
        check("async.ready",    64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ptr   = 0;
        last  = '0;
        sb.delete();

        // Random traffic honouring the hold-until-granted contract.
        v = '0;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    v[i] = 1'b1;
                    set_req(i, ($urandom_range(0, 3) == 0) ? AW'(ZREG) : AW'($urandom_range(0, 30)),
                            {$urandom, $urandom});
                end
            end
            step(v, ($urandom_range(0, 3) == 0), "rand", g);
            if (g >= 0) v[g] = 1'b0;
        end
        step('0, 1'b0, "drain", g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
